// File: rtl/rk_fb_pkg.sv
// Shared constants and encodings for the Radio-86RK framebuffer port-A arbiter.
package rk_fb_pkg;

   localparam int FB_W     = 408;
   localparam int FB_H     = 300;
   localparam int FB_WORDS = FB_W * FB_H;
   localparam int ADDR_W   = 18;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_CAP,
      SRC_CLR,
      SRC_AUX
   } src_e;

   typedef enum logic [1:0] {
      CLR_IDLE,
      CLR_RUN,
      CLR_DONE
   } clr_state_e;

endpackage

// File: rtl/rk_fb_clear.sv
// Bulk clear sequencer: walks the framebuffer once, advancing only when stepped.
module rk_fb_clear #(
   parameter int ADDR_W   = rk_fb_pkg::ADDR_W,
   parameter int FB_WORDS = rk_fb_pkg::FB_WORDS
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic              value_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              data_o,
   output logic              busy_o,
   output logic              done_o
);
   import rk_fb_pkg::*;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_WORDS - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              val_q, val_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= CLR_IDLE;
         ptr_q   <= '0;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         val_q   <= val_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      val_d   = val_q;
      unique case (state_q)
         CLR_IDLE: begin
            if (start_i) begin
               state_d = CLR_RUN;
               ptr_d   = '0;
               val_d   = value_i;
            end
         end
         CLR_RUN: begin
            if (step_i) begin
               if (ptr_q == LAST) state_d = CLR_DONE;
               else ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         CLR_DONE: state_d = CLR_IDLE;
         default:  state_d = CLR_IDLE;
      endcase
   end

   assign addr_o = ptr_q;
   assign data_o = val_q;
   assign busy_o = (state_q != CLR_IDLE);
   assign done_o = (state_q == CLR_DONE);

endmodule

// File: rtl/rk_fb_arbiter.sv
// Port-A arbiter for the 1-bit video framebuffer: capture > clear > aux,
// registered RAM issue and a two-stage aux read return path.
module rk_fb_arbiter #(
   parameter int ADDR_W   = rk_fb_pkg::ADDR_W,
   parameter int FB_WORDS = rk_fb_pkg::FB_WORDS,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cap_we,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic              cap_data,
   input  logic              clr_start,
   input  logic              clr_value,
   output logic              clr_busy,
   output logic              clr_done,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic              aux_wdata,
   output logic              aux_gnt,
   output logic              aux_rvalid,
   output logic              aux_rdata,
   output logic [CNT_W-1:0]  aux_stall_cnt,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_data,
   output logic              ram_wren,
   output logic              ram_rden,
   input  logic              ram_q
);
   import rk_fb_pkg::*;

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(FB_WORDS);

   logic [ADDR_W-1:0] clr_addr;
   logic              clr_data;
   logic              clr_run;
   logic              cap_ok, aux_ok;
   src_e              src;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              data_q, data_d;
   logic              wren_q, wren_d;
   logic              rden_q, rden_d;
   logic              rd1_q, rd1_d, oor1_q, oor1_d;
   logic              rd2_q, oor2_q;
   logic              rvalid_q, rdata_q;
   logic [CNT_W-1:0]  stall_q, stall_d;

   rk_fb_clear #(
      .ADDR_W   (ADDR_W),
      .FB_WORDS (FB_WORDS)
   ) u_clear (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (clr_start),
      .value_i (clr_value),
      .step_i  (~cap_we),
      .addr_o  (clr_addr),
      .data_o  (clr_data),
      .busy_o  (clr_busy),
      .done_o  (clr_done)
   );

   assign clr_run = clr_busy & ~clr_done;
   assign aux_gnt = aux_req & ~cap_we & ~clr_busy;
   assign cap_ok  = (cap_addr < LIMIT);
   assign aux_ok  = (aux_addr < LIMIT);

   always_comb begin
      src = SRC_NONE;
      priority case (1'b1)
         cap_we:  src = SRC_CAP;
         clr_run: src = SRC_CLR;
         aux_gnt: src = SRC_AUX;
         default: src = SRC_NONE;
      endcase
   end

   // Out-of-range slots are consumed but leave the RAM port idle.
   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      wren_d = 1'b0;
      rden_d = 1'b0;
      rd1_d  = 1'b0;
      oor1_d = 1'b0;
      unique case (src)
         SRC_CAP: begin
            if (cap_ok) begin
               addr_d = cap_addr;
               data_d = cap_data;
               wren_d = 1'b1;
            end
         end
         SRC_CLR: begin
            addr_d = clr_addr;
            data_d = clr_data;
            wren_d = 1'b1;
         end
         SRC_AUX: begin
            if (aux_we) begin
               if (aux_ok) begin
                  addr_d = aux_addr;
                  data_d = aux_wdata;
                  wren_d = 1'b1;
               end
            end else begin
               rd1_d  = 1'b1;
               oor1_d = ~aux_ok;
               if (aux_ok) begin
                  addr_d = aux_addr;
                  rden_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      if (aux_req && !aux_gnt && stall_q != '1)
         stall_d = stall_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_q   <= '0;
         data_q   <= 1'b0;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
         rd1_q    <= 1'b0;
         oor1_q   <= 1'b0;
         rd2_q    <= 1'b0;
         oor2_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= 1'b0;
         stall_q  <= '0;
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         wren_q   <= wren_d;
         rden_q   <= rden_d;
         rd1_q    <= rd1_d;
         oor1_q   <= oor1_d;
         rd2_q    <= rd1_q;
         oor2_q   <= oor1_q;
         rvalid_q <= rd2_q;
         if (rd2_q) rdata_q <= ram_q & ~oor2_q;
         stall_q  <= stall_d;
      end
   end

   assign ram_addr      = addr_q;
   assign ram_data      = data_q;
   assign ram_wren      = wren_q;
   assign ram_rden      = rden_q;
   assign aux_rvalid    = rvalid_q;
   assign aux_rdata     = rdata_q;
   assign aux_stall_cnt = stall_q;

endmodule

// File: tb/tb_rk_fb_arbiter.sv
// Directed bench for rk_fb_arbiter with a behavioural port-A RAM model.
module tb_rk_fb_arbiter;

   localparam int AW = 18;
   localparam int N  = 1200;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cap_we, cap_data;
   logic [AW-1:0] cap_addr;
   logic          clr_start, clr_value, clr_busy, clr_done;
   logic          aux_req, aux_we, aux_wdata;
   logic [AW-1:0] aux_addr;
   logic          aux_gnt, aux_rvalid, aux_rdata;
   logic [CW-1:0] aux_stall_cnt;
   logic [AW-1:0] ram_addr;
   logic          ram_data, ram_wren, ram_rden, ram_q;

   int checks = 0;
   int errors = 0;

   logic mem [0:2**AW-1];
   logic trk_en, trk_val, trk_clr;
   int   trk_next = 0;
   int   trk_bad = 0;

   always #5 clk = ~clk;

   rk_fb_arbiter #(
      .ADDR_W   (AW),
      .FB_WORDS (N),
      .CNT_W    (CW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cap_we        (cap_we),
      .cap_addr      (cap_addr),
      .cap_data      (cap_data),
      .clr_start     (clr_start),
      .clr_value     (clr_value),
      .clr_busy      (clr_busy),
      .clr_done      (clr_done),
      .aux_req       (aux_req),
      .aux_we        (aux_we),
      .aux_addr      (aux_addr),
      .aux_wdata     (aux_wdata),
      .aux_gnt       (aux_gnt),
      .aux_rvalid    (aux_rvalid),
      .aux_rdata     (aux_rdata),
      .aux_stall_cnt (aux_stall_cnt),
      .ram_addr      (ram_addr),
      .ram_data      (ram_data),
      .ram_wren      (ram_wren),
      .ram_rden      (ram_rden),
      .ram_q         (ram_q)
   );

   // RAM model plus a tracker for the clear address sequence
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_data;
      if (ram_rden) ram_q <= mem[ram_addr];
      if (trk_clr) begin
         trk_next <= 0;
         trk_bad  <= 0;
      end else if (trk_en && ram_wren && ram_data == trk_val) begin
         if (ram_addr != AW'(trk_next)) trk_bad <= trk_bad + 1;
         trk_next <= trk_next + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int k;
      int ncap;
      int bad;
      int done_seen;

      reset_n = 1'b0;
      cap_we = 1'b0; cap_addr = '0; cap_data = 1'b0;
      clr_start = 1'b0; clr_value = 1'b0;
      aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = 1'b0;
      trk_en = 1'b0; trk_val = 1'b0; trk_clr = 1'b1;
      repeat (3) step();
      trk_clr = 1'b0;

      chk("rst_wren",   32'(ram_wren), 0);
      chk("rst_rden",   32'(ram_rden), 0);
      chk("rst_addr",   32'(ram_addr), 0);
      chk("rst_data",   32'(ram_data), 0);
      chk("rst_busy",   32'(clr_busy), 0);
      chk("rst_done",   32'(clr_done), 0);
      chk("rst_rvalid", 32'(aux_rvalid), 0);
      chk("rst_rdata",  32'(aux_rdata), 0);
      chk("rst_stall",  32'(aux_stall_cnt), 0);
      reset_n = 1'b1;
      step();

      // aux write 5=1 then read it back
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = AW'(5); aux_wdata = 1'b1;
      #1;
      chk("gnt_idle", 32'(aux_gnt), 1);
      step();
      chk("wr_wren", 32'(ram_wren), 1);
      chk("wr_addr", 32'(ram_addr), 5);
      chk("wr_data", 32'(ram_data), 1);
      aux_we = 1'b0;
      step();
      chk("rd_rden", 32'(ram_rden), 1);
      chk("rd_wren", 32'(ram_wren), 0);
      aux_req = 1'b0;
      step();
      chk("rd_rv_early", 32'(aux_rvalid), 0);
      chk("idle_rden",   32'(ram_rden), 0);
      chk("idle_addr",   32'(ram_addr), 5);
      step();
      chk("rd_rvalid", 32'(aux_rvalid), 1);
      chk("rd_rdata",  32'(aux_rdata), 1);
      step();
      chk("rd_rv_pulse", 32'(aux_rvalid), 0);

      // back-to-back reads, second one out of range
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = AW'(5);
      step();
      chk("b2b_rden0", 32'(ram_rden), 1);
      aux_addr = AW'(N);
      step();
      chk("oor_rden", 32'(ram_rden), 0);
      aux_we = 1'b1; aux_addr = AW'(N + 5); aux_wdata = 1'b1;
      step();
      chk("oor_wr_wren", 32'(ram_wren), 0);
      chk("b2b_rv0",     32'(aux_rvalid), 1);
      chk("b2b_rd0",     32'(aux_rdata), 1);
      aux_req = 1'b0;
      step();
      chk("oor_rvalid", 32'(aux_rvalid), 1);
      chk("oor_rdata",  32'(aux_rdata), 0);
      step();
      chk("oor_rv_end", 32'(aux_rvalid), 0);

      // capture: out-of-range dropped, in-range written
      cap_we = 1'b1; cap_addr = AW'(N + 100); cap_data = 1'b1;
      step();
      chk("cap_oor_wren", 32'(ram_wren), 0);
      cap_addr = AW'(20);
      step();
      chk("cap_wren", 32'(ram_wren), 1);
      chk("cap_addr", 32'(ram_addr), 20);
      chk("cap_data", 32'(ram_data), 1);
      cap_we = 1'b0;
      step();
      chk("cap_idle", 32'(ram_wren), 0);

      // aux held through 10 captures
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = AW'(20);
      for (int i = 0; i < 10; i++) begin
         cap_we = 1'b1; cap_addr = AW'(30 + i); cap_data = 1'b0;
         #1;
         chk("stall_gnt", 32'(aux_gnt), 0);
         step();
      end
      cap_we = 1'b0;
      #1;
      chk("stall_cnt", 32'(aux_stall_cnt), 10);
      chk("stall_gnt_after", 32'(aux_gnt), 1);
      step();
      chk("stall_rden", 32'(ram_rden), 1);
      aux_req = 1'b0;
      step();
      step();
      chk("stall_rvalid", 32'(aux_rvalid), 1);
      chk("stall_rdata",  32'(aux_rdata), 1);

      // clr_start with aux on same edge, then clear with captures every 3rd cycle
      trk_val = 1'b1; trk_clr = 1'b1;
      step();
      trk_clr = 1'b0; trk_en = 1'b1;
      clr_start = 1'b1; clr_value = 1'b1;
      aux_req = 1'b1; aux_we = 1'b1; aux_addr = AW'(40); aux_wdata = 1'b0;
      #1;
      chk("start_aux_gnt", 32'(aux_gnt), 1);
      step();
      chk("start_aux_wren", 32'(ram_wren), 1);
      chk("start_aux_addr", 32'(ram_addr), 40);
      chk("start_busy",     32'(clr_busy), 1);
      clr_start = 1'b0; aux_req = 1'b0;
      k = 0; ncap = 0;
      while (!clr_done && k < 2 * N) begin
         if (k % 3 == 2) begin
            cap_we = 1'b1; cap_addr = AW'(ncap); cap_data = 1'b0;
            ncap++;
         end else begin
            cap_we = 1'b0;
         end
         step();
         k++;
      end
      cap_we = 1'b0;
      chk("clrcap_dur",  k, N + ncap);
      chk("clrcap_busy", 32'(clr_busy), 1);
      step();
      chk("clrcap_busy_off", 32'(clr_busy), 0);
      chk("clrcap_done_off", 32'(clr_done), 0);
      step();
      trk_en = 1'b0;
      chk("clrcap_seq_cnt", trk_next, N);
      chk("clrcap_seq_bad", trk_bad, 0);
      bad = 0;
      for (int i = 0; i < N; i++)
         if (mem[i] !== ((i < ncap) ? 1'b0 : 1'b1)) bad++;
      chk("clrcap_mem", bad, 0);

      // uncontended clear of 0s; aux held early drives stall count to saturation
      trk_val = 1'b0; trk_clr = 1'b1;
      step();
      trk_clr = 1'b0; trk_en = 1'b1;
      clr_start = 1'b1; clr_value = 1'b0;
      step();
      clr_start = 1'b0;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = AW'(5);
      #1;
      chk("busy_gnt", 32'(aux_gnt), 0);
      k = 0;
      while (!clr_done && k < 2 * N) begin
         aux_req = (k < 8);
         clr_start = (k == 50);
         step();
         k++;
      end
      aux_req = 1'b0; clr_start = 1'b0;
      chk("unc_dur",   k, N);
      chk("sat_stall", 32'(aux_stall_cnt), 15);
      step();
      chk("unc_busy_off", 32'(clr_busy), 0);
      step();
      trk_en = 1'b0;
      chk("unc_seq_cnt", trk_next, N);
      chk("unc_seq_bad", trk_bad, 0);

      // reset in the middle of a clear
      clr_start = 1'b1; clr_value = 1'b1;
      step();
      clr_start = 1'b0;
      k = 0;
      while (!(ram_wren && ram_addr == AW'(500)) && k < 2 * N) begin
         step();
         k++;
      end
      chk("mid_reach", 32'(ram_addr), 500);
      reset_n = 1'b0;
      step();
      chk("mid_wren",  32'(ram_wren), 0);
      chk("mid_addr",  32'(ram_addr), 0);
      chk("mid_data",  32'(ram_data), 0);
      chk("mid_busy",  32'(clr_busy), 0);
      chk("mid_stall", 32'(aux_stall_cnt), 0);
      reset_n = 1'b1;
      done_seen = 0;
      repeat (5) begin
         step();
         if (clr_done) done_seen++;
      end
      chk("mid_no_done", done_seen, 0);
      chk("mid_idle_wren", 32'(ram_wren), 0);

      // reset while an aux read is in flight
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = AW'(5);
      step();
      chk("inflt_rden", 32'(ram_rden), 1);
      aux_req = 1'b0; reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      chk("inflt_rv_drop", 32'(aux_rvalid), 0);
      step();
      chk("inflt_rv_drop2", 32'(aux_rvalid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rk_fb_arbiter.md
# rk_fb_arbiter

Arbiter and sequencer for write/read port A of the 1-bit 408×300 video framebuffer (122400 words) used by the Radio-86RK display path. It shares that single RAM port between three requesters:
- the pixel capture stream from the WG75 timing logic (highest priority, never stalled);
- a built-in bulk clear engine;
- an auxiliary read/write port for OSD or test-pattern logic.

The block sits between the 48 MHz capture logic and the dual-port `rambuffer`; the VGA read side on port B is untouched.

## Interface
- `ADDR_W`, 18, framebuffer address width
- `FB_WORDS`, 122400, number of valid framebuffer words (408×300)
- `CNT_W`, 16, width of the aux stall counter

- `clk` in 1: system clock (48 MHz), all logic on rising edge
- `reset_n` in 1: reset, synchronous, active-low
- `cap_we` in 1: capture write strobe, one word per asserted cycle
- `cap_addr` in `ADDR_W`: capture address
- `cap_data` in 1: capture pixel
- `clr_start` in 1: start a clear, sampled on the rising edge
- `clr_value` in 1: fill value, latched at start
- `clr_busy` out 1: clear in progress
- `clr_done` out 1: one-cycle pulse when the clear completes
- `aux_req` in 1: aux access request, held until granted
- `aux_we` in 1: 1 = write, 0 = read
- `aux_addr` in `ADDR_W`: aux address
- `aux_wdata` in 1: aux write data
- `aux_gnt` out 1: combinational grant
- `aux_rvalid` out 1: read data valid
- `aux_rdata` out 1: read data
- `aux_stall_cnt` out `CNT_W`: saturating count of cycles with `aux_req` high and `aux_gnt` low
- `ram_addr` out `ADDR_W`: RAM port A address (registered)
- `ram_data` out 1: RAM write data (registered)
- `ram_wren` out 1: RAM write enable (registered)
- `ram_rden` out 1: RAM read enable (registered)
- `ram_q` in 1: RAM read data, valid one clock after the RAM samples `ram_rden`

## Operation
- **Fixed priority per cycle:** capture > clear > aux. The winner is issued; losers hold their state.
- **Capture:**
  - `cap_we` always wins.
  - A capture with `cap_addr >= FB_WORDS` is dropped: no RAM access, and the slot is still consumed.
- **Clear FSM**, states `IDLE`, `RUN`, `DONE`:
  - `IDLE` → `RUN` on `clr_start`. At the transition, latch `clr_value` and set the pointer to 0.
  - `RUN`: on each cycle without `cap_we`, issue write(pointer, value) and increment the pointer.
  - `RUN` → `DONE` when word `FB_WORDS-1` has been issued.
  - `DONE` → `IDLE` after one cycle, with `clr_done` high in that cycle.
  - `clr_busy` is high in `RUN` and `DONE`.
  - `clr_start` is ignored while busy.
- **Aux:**
  - `aux_gnt = aux_req & ~cap_we & ~clr_busy`.
  - A transfer is accepted on the edge where `aux_req & aux_gnt`.
  - An out-of-range write is accepted and discarded.
  - An out-of-range read is accepted, drives no RAM access, and returns `aux_rdata = 0` with normal `aux_rvalid` timing.
- **Stall counter:** increments on each cycle with `aux_req & ~aux_gnt` and saturates at all-ones. It clears only on reset.
- **RAM port:**
  - `ram_wren` and `ram_rden` are mutually exclusive and never high together.
  - In a cycle with no issue, both enables are 0. `ram_addr` and `ram_data` hold their previous values.

## Timing
- **Reset values:**
  - `ram_addr` = 0, `ram_data` = 0, `ram_wren` = 0, `ram_rden` = 0.
  - `clr_busy` = 0, `clr_done` = 0.
  - `aux_rvalid` = 0, `aux_rdata` = 0, `aux_stall_cnt` = 0.
  - FSM in `IDLE`.
- **Issue latency:** a request accepted at edge N appears on the `ram_*` outputs after edge N (cycle N+1).
- **Aux read latency:**
  - `aux_rvalid` is high for exactly one cycle, after edge N+2, with `aux_rdata` = `ram_q` registered.
  - Back-to-back aux reads give back-to-back `rvalid` in order.
- **Clear duration:** `FB_WORDS` cycles plus one for `DONE` when uncontended. Each `cap_we` cycle adds one.
- **Reset mid-clear:** aborts with no `clr_done`. Words already written stay written.
- **Reset with an aux read in flight:** the pending `rvalid` is discarded.
- **Same-edge collisions:**
  - `clr_start` and `aux_req` on the same edge: aux is granted that cycle (`clr_busy` is still 0); the clear begins on the next cycle.
  - `clr_start` and `cap_we` on the same edge: the capture is issued and the clear enters `RUN` anyway.

## Structure
- Package `rk_fb_pkg` holds:
  - `FB_W` = 408, `FB_H` = 300, `FB_WORDS`, `ADDR_W`;
  - the source-select encoding `SRC_NONE`, `SRC_CAP`, `SRC_CLR`, `SRC_AUX`;
  - the clear state encoding.
- Sub-module `rk_fb_clear` contains the clear FSM and address pointer, with a `step` input and `addr`, `busy`, `done` outputs. The arbitration mux and the aux read pipeline stay in the top module.

## Test plan
- **Clear, uncontended:** `clr_start`, `clr_value` = 1, no other traffic → 122400 consecutive `ram_wren` at addresses 0..122399, then `clr_done` pulse at cycle 122401, `clr_busy` low the cycle after.
- **Clear with capture:** `cap_we` asserted every 3rd cycle during a clear → every capture address is written with `cap_data`, the clear address sequence has no gaps or repeats, and total duration grows by exactly the capture count.
- **Aux read latency:** idle, then aux write addr 5 = 1, then read addr 5 → `aux_rvalid` two cycles after acceptance with `aux_rdata` = 1.
- **Aux stalls:** `aux_req` held during 10 consecutive `cap_we` cycles → `aux_gnt` low for 10 cycles, `aux_stall_cnt` = 10, then grant.
- **Out of range:** aux read at 122400 → no `ram_rden`, `rvalid` with 0. Capture at 130000 → no `ram_wren`.
- **Reset mid-clear:** assert `reset_n` = 0 at clear word 5000 → all outputs at reset values next cycle, no `clr_done`.
